// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: rising edges of i_spike add WEIGHT to a
// saturating membrane potential that leaks linearly; crossing THRESHOLD emits a pulse.
module lif_neuron #(
  parameter int WEIGHT       = 100,
  parameter int THRESHOLD    = 1000,
  parameter int LEAK_PERIOD  = 1000,
  parameter int LEAK_AMOUNT  = 1,
  parameter int SPIKE_LENGTH = 10,
  parameter int REFRACTORY   = 100,
  parameter int POT_WIDTH    = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 i_spike,
  output logic                 o_spike,
  output logic [POT_WIDTH-1:0] potential_debug,
  output logic [31:0]          fire_count_debug
);

  localparam int LCW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int FCW = $clog2(SPIKE_LENGTH + 1);
  localparam int RCW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

  localparam logic [POT_WIDTH:0]   WEIGHT_EXT = (POT_WIDTH + 1)'(WEIGHT);
  localparam logic [POT_WIDTH-1:0] LEAK_AMT   = POT_WIDTH'(LEAK_AMOUNT);
  localparam logic [POT_WIDTH-1:0] THRESH     = POT_WIDTH'(THRESHOLD);
  localparam logic [LCW-1:0]       LEAK_LAST  = LCW'(LEAK_PERIOD - 1);
  localparam logic [FCW-1:0]       SPIKE_LAST = FCW'(SPIKE_LENGTH);
  localparam logic [RCW-1:0]       REFR_LAST  = RCW'(REFRACTORY);

  typedef enum logic [1:0] {
    ST_INTEGRATE,
    ST_FIRING,
    ST_REFRACTORY
  } state_t;

  state_t               r_state;
  logic                 r_prev;
  logic                 r_spike;
  logic [POT_WIDTH-1:0] r_pot;
  logic [LCW-1:0]       r_leak_cnt;
  logic [FCW-1:0]       r_fire_cnt;
  logic [RCW-1:0]       r_refr_cnt;
  logic [31:0]          r_fire_count;

  logic                 w_event;
  logic                 w_leak;
  logic [POT_WIDTH:0]   w_sum;
  logic [POT_WIDTH-1:0] w_added;
  logic [POT_WIDTH-1:0] w_next;
  logic                 w_fire;

  // Add-then-subtract: saturate high on the weight, clamp at zero on the leak.
  always_comb begin
    w_event = i_spike & ~r_prev;
    w_leak  = (r_leak_cnt == LEAK_LAST);
    w_sum   = {1'b0, r_pot} + (w_event ? WEIGHT_EXT : '0);
    w_added = w_sum[POT_WIDTH] ? '1 : w_sum[POT_WIDTH-1:0];
    w_next  = w_added;
    if (w_leak) begin
      w_next = (w_added > LEAK_AMT) ? (w_added - LEAK_AMT) : '0;
    end
    w_fire  = (w_next >= THRESH);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state      <= ST_INTEGRATE;
      r_prev       <= 1'b1;
      r_spike      <= 1'b0;
      r_pot        <= '0;
      r_leak_cnt   <= '0;
      r_fire_cnt   <= '0;
      r_refr_cnt   <= '0;
      r_fire_count <= '0;
    end else begin
      r_prev <= i_spike;
      unique case (r_state)
        ST_INTEGRATE: begin
          if (w_fire) begin
            r_pot        <= '0;
            r_spike      <= 1'b1;
            r_fire_cnt   <= FCW'(1);
            r_fire_count <= r_fire_count + 32'd1;
            r_leak_cnt   <= '0;
            r_state      <= ST_FIRING;
          end else begin
            r_pot      <= w_next;
            r_leak_cnt <= w_leak ? '0 : (r_leak_cnt + LCW'(1));
          end
        end
        ST_FIRING: begin
          if (r_fire_cnt == SPIKE_LAST) begin
            r_spike    <= 1'b0;
            r_fire_cnt <= '0;
            if (REFRACTORY == 0) begin
              r_state <= ST_INTEGRATE;
            end else begin
              r_state    <= ST_REFRACTORY;
              r_refr_cnt <= RCW'(1);
            end
          end else begin
            r_fire_cnt <= r_fire_cnt + FCW'(1);
          end
        end
        ST_REFRACTORY: begin
          if (r_refr_cnt == REFR_LAST) begin
            r_state    <= ST_INTEGRATE;
            r_refr_cnt <= '0;
          end else begin
            r_refr_cnt <= r_refr_cnt + RCW'(1);
          end
        end
        default: r_state <= ST_INTEGRATE;
      endcase
    end
  end

  assign o_spike          = r_spike;
  assign potential_debug  = r_pot;
  assign fire_count_debug = r_fire_count;

endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Single leaky integrate-and-fire neuron directly downstream of the VCO frequency reducer; consumes its stretched spike pulses on i_spike.
- Each input spike adds a fixed weight to a membrane potential. The potential leaks linearly over time.
- When the potential reaches threshold, the block emits a fixed-length output spike, clears the potential and enters a refractory period.
- Output format matches the reducer (level pulse, SPIKE_LENGTH cycles), so neurons can be chained.

Parameters:
- WEIGHT, 100: potential added per detected input spike.
- THRESHOLD, 1000: fire when potential >= THRESHOLD; range 1..2^POT_WIDTH-1.
- LEAK_PERIOD, 1000: sys_clk cycles between leak events; >=1.
- LEAK_AMOUNT, 1: potential subtracted per leak event.
- SPIKE_LENGTH, 10: cycles o_spike is held high per fire; >=1.
- REFRACTORY, 100: cycles after the output spike during which input is ignored; 0 allowed.
- POT_WIDTH, 16: membrane potential width in bits.

Ports:
- sys_clk  input  1  system clock, 100 MHz.
- rst  input  1  synchronous reset, active-high.
- i_spike  input  1  input spike level from the frequency reducer (sys_clk domain, no synchroniser needed).
- o_spike  output  1  output spike, registered.
- potential_debug  output  POT_WIDTH  current membrane potential.
- fire_count_debug  output  32  number of fires since reset, wraps at 2^32.

Behaviour:
- One clock, sys_clk. Reset is synchronous and active-high.
- On rst, at the next edge: o_spike=0, potential=0, leak counter=0, fire/refractory counters=0, fire_count=0, state=INTEGRATE, prev_spike=1. Setting prev_spike=1 means a level already high at reset release is not counted.
- Edge detect: event = i_spike & ~prev_spike. prev_spike <= i_spike every cycle in all states. An input held high across a state change never produces a second event.
- States: INTEGRATE, FIRING, REFRACTORY.
- INTEGRATE:
  - Leak counter increments each cycle. When it equals LEAK_PERIOD-1 it wraps to 0 and a leak event occurs in that cycle.
  - Next potential = sat_sub(sat_add(potential, event ? WEIGHT : 0), leak ? LEAK_AMOUNT : 0).
  - sat_add clamps at 2^POT_WIDTH-1. sat_sub clamps at 0. Never wrap.
  - If next potential >= THRESHOLD: potential <= 0, o_spike <= 1, fire counter <= 1, fire_count increments, state <= FIRING. Otherwise potential <= next potential.
  - Latency: the edge sampling a crossing event is the edge at which o_spike goes high (one cycle after i_spike rises).
- FIRING:
  - o_spike stays high. Input events are ignored. Potential is held at 0. Leak counter is held at 0.
  - When fire counter == SPIKE_LENGTH: o_spike <= 0 and state <= REFRACTORY, or INTEGRATE if REFRACTORY==0. Otherwise fire counter increments.
  - o_spike is therefore high for exactly SPIKE_LENGTH cycles.
- REFRACTORY:
  - o_spike=0. Events are ignored. Potential is held at 0.
  - Refractory counter starts at 1. When it equals REFRACTORY, state <= INTEGRATE and the counter clears. The block spends exactly REFRACTORY cycles here.
  - Leak counter restarts from 0 on entry to INTEGRATE.
- Simultaneous event and leak in the same cycle: add first, then subtract, as in the formula above.
- A single event may cross threshold even if WEIGHT > THRESHOLD. No carry-over: excess potential is discarded on fire.
- Reset during FIRING or REFRACTORY: the next cycle is the full reset state; o_spike drops immediately at that edge.
- potential_debug mirrors the potential register. fire_count_debug mirrors the fire counter.

Test Plan:
(All cases use WEIGHT=100, THRESHOLD=300, LEAK_PERIOD=50, LEAK_AMOUNT=10, SPIKE_LENGTH=4, REFRACTORY=8 unless stated.)
- Fire: i_spike rises at cycles 5, 15, 25 (each high 3 cycles). Potential reads 100, 200, then o_spike goes high the cycle after the third rise, for exactly 4 cycles. Potential reads 0, fire_count_debug=1.
- Leak floor: one input pulse gives potential 100. Over the next 600 idle cycles the potential decreases by 10 every 50 cycles, reaches 0 and stays 0 with no underflow. o_spike is never asserted.
- Refractory ignore: fire as above, then pulse i_spike during FIRING and during REFRACTORY. Potential stays 0 and no extra fire occurs. A rise 2 cycles after REFRACTORY ends gives potential 100.
- Held input: i_spike held high from before a fire through the end of REFRACTORY. No event is counted on return to INTEGRATE. The potential increases only on the next true rising edge.
- Saturation (POT_WIDTH=16, WEIGHT=30000, THRESHOLD=65535, LEAK_AMOUNT=0): three rises give potentials 30000, 60000, then saturate to 65535 and fire. Potential returns to 0.
- Reset mid-fire plus coincidence: assert rst on the 2nd cycle of FIRING; the next cycle shows o_spike=0, potential=0, fire_count_debug=0. Separately, a rise on the exact leak-event cycle with potential 50 yields 140.
